// File: rtl/algofoogle_product_pkg.sv
// Shared types and constants for the two-requester product scheduler.
//   state_t : scheduler FSM phases (IDLE, LOAD, CALC, OUT)
//   rsp_t   : response FIFO entry {id, 32-bit product}
package algofoogle_product_pkg;

  localparam int unsigned N_NIBBLES = 8;
  localparam int unsigned N_BYTES   = 4;
  localparam int unsigned RSP_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    OUT
  } state_t;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } rsp_t;

endpackage

// File: rtl/algofoogle_product_rsp_fifo.sv
// Two-entry synchronous response FIFO.
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push        : write push_data this cycle
//   push_data   : {id, data}
//   pop         : remove the head entry this cycle (ignored when empty)
//   valid       : head entry present
//   head        : head entry, zero when empty
//   occ         : number of stored entries (0..2)
// Push and pop in the same cycle are allowed, including when full.
module algofoogle_product_rsp_fifo
  import algofoogle_product_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [32:0] push_data,
  input  logic        pop,
  output logic        valid,
  output logic [32:0] head,
  output logic [1:0]  occ
);

  rsp_t       mem [RSP_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'(RSP_DEPTH)) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    valid = (count != 2'd0);
    head  = valid ? mem[rd_ptr] : '0;
    occ   = count;
  end

endmodule

// File: rtl/algofoogle_product_sched.sv
// Two-requester scheduler for the nibble-serial 16x16 multiplier core.
//   clk, reset        : clock shared with the core; synchronous active-high reset
//   req_valid[1:0]    : per-requester request valid
//   req_ready[1:0]    : per-requester accept (one-hot or zero, combinational)
//   req0_a/b, req1_a/b: 16-bit operands of each requester
//   rsp_valid/ready   : response handshake (FIFO head)
//   rsp_id, rsp_data  : requester index and unsigned a*b of the head result
//   mul_reset         : core reset
//   mul_nibble        : core nibble input (a[15:12] first, b[3:0] last)
//   mul_byte          : core byte output, product MSB first
//   busy              : high whenever the FSM is not IDLE
module algofoogle_product_sched
  import algofoogle_product_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        mul_reset,
  output logic [3:0]  mul_nibble,
  input  logic [7:0]  mul_byte,
  output logic        busy
);

  state_t      state;
  state_t      state_nx;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nx;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_id;
  logic [31:0] result;
  logic        prio;

  logic        push_rsp;
  logic        fifo_pop;
  logic [1:0]  fifo_occ;
  logic [32:0] fifo_head;
  logic        accept_window;
  logic        room;
  logic        winner;
  logic        grant;
  logic [31:0] ab_shifted;

  // Arbitration and accept window
  always_comb begin
    push_rsp      = (state == OUT) && (cnt == 3'(N_BYTES - 1));
    accept_window = (state == IDLE) || push_rsp;
    fifo_pop      = rsp_valid && rsp_ready;
    // Occupancy after this cycle's push/pop must leave a slot for the new job.
    room   = (({1'b0, fifo_occ} + {2'b00, push_rsp}) - {2'b00, fifo_pop}) <= 3'd1;
    winner = (req_valid == 2'b11) ? prio : req_valid[1];
    grant  = !reset && accept_window && room && (req_valid != 2'b00);
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nx = LOAD;
          cnt_nx   = '0;
        end
      end
      LOAD: begin
        if (cnt == 3'(N_NIBBLES - 1)) begin
          state_nx = CALC;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      CALC: begin
        state_nx = OUT;
        cnt_nx   = '0;
      end
      OUT: begin
        if (cnt == 3'(N_BYTES - 1)) begin
          state_nx = grant ? LOAD : IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      prio   <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_id  <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (grant) begin
        op_a  <= winner ? req1_a : req0_a;
        op_b  <= winner ? req1_b : req0_b;
        op_id <= winner;
        prio  <= ~winner;
      end
      // Bytes arrive MSB first; shifting them in leaves byte 0 at [31:24].
      if (state == OUT) begin
        result <= {result[23:0], mul_byte};
      end
    end
  end

  // Core drive
  always_comb begin
    ab_shifted = {op_a, op_b} << {cnt, 2'b00};
    mul_nibble = (state == LOAD) ? ab_shifted[31:28] : '0;
    // Resetting the core in OUT3 discards its wrap-around shift.
    mul_reset  = reset || (state == IDLE) || push_rsp;
    busy       = (state != IDLE);
  end

  algofoogle_product_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_rsp),
    .push_data ({op_id, result[23:0], mul_byte}),
    .pop       (fifo_pop),
    .valid     (rsp_valid),
    .head      (fifo_head),
    .occ       (fifo_occ)
  );

  always_comb begin
    rsp_id   = fifo_head[32];
    rsp_data = fifo_head[31:0];
  end

endmodule

// File: tb/tb_algofoogle_product_sched.sv
module tb_algofoogle_product_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        mul_reset;
  logic [3:0]  mul_nibble;
  logic [7:0]  mul_byte;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  algofoogle_product_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .mul_reset  (mul_reset),
    .mul_nibble (mul_nibble),
    .mul_byte   (mul_byte),
    .busy       (busy)
  );

  // Behavioural nibble-serial multiplier core: 8 nibbles in, one
  // multiply cycle, then product bytes MSB first.
  logic [31:0] core_sh;
  logic [3:0]  core_cnt;
  always @(posedge clk) begin
    if (mul_reset) begin
      core_sh  <= '0;
      core_cnt <= '0;
    end else if (core_cnt < 4'd8) begin
      core_sh  <= {core_sh[27:0], mul_nibble};
      core_cnt <= core_cnt + 4'd1;
    end else if (core_cnt == 4'd8) begin
      core_sh  <= {16'h0, core_sh[31:16]} * {16'h0, core_sh[15:0]};
      core_cnt <= 4'd9;
    end else begin
      core_sh  <= core_sh << 8;
      if (core_cnt != 4'd15) core_cnt <= core_cnt + 4'd1;
    end
  end
  assign mul_byte = (core_cnt >= 4'd9) ? core_sh[31:24] : 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
  endtask

  // Requester stimulus queues: {a, b}
  logic [31:0] rq0[$];
  logic [31:0] rq1[$];

  initial begin
    req_valid = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    forever begin
      @(posedge clk);
      #1;
      req_valid[0] = (rq0.size() != 0);
      req_valid[1] = (rq1.size() != 0);
      if (rq0.size() != 0) {req0_a, req0_b} = rq0[0];
      if (rq1.size() != 0) {req1_a, req1_b} = rq1[0];
    end
  end

  // Scoreboard and reference arbitration model
  logic [32:0] exp_q[$];
  int          grant_id[$];
  int          grant_cyc[$];
  logic        prio_m;
  logic        held;
  logic [32:0] held_val;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      prio_m = 1'b0;
      held   = 1'b0;
    end else begin
      check("ready_onehot_valid",
            {63'd0, ((req_ready & ~req_valid) != 2'b00) || (req_ready == 2'b11)}, 64'd0);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          logic [15:0] a, b;
          logic [31:0] p;
          int          w;
          w = (req_valid == 2'b11) ? int'(prio_m) : (req_valid[1] ? 1 : 0);
          check("grant_winner", 64'(i), 64'(w));
          a = (i == 1) ? req1_a : req0_a;
          b = (i == 1) ? req1_b : req0_b;
          p = {16'h0, a} * {16'h0, b};
          exp_q.push_back({1'(i), p});
          prio_m = (i == 0);
          grant_id.push_back(i);
          grant_cyc.push_back(cyc);
          if (i == 0) void'(rq0.pop_front());
          else        void'(rq1.pop_front());
        end
      end
      if (held) begin
        check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
        check("rsp_hold_data", 64'({rsp_id, rsp_data}), 64'(held_val));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail("rsp_unexpected");
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e[32]));
          check("rsp_data", 64'(rsp_data), 64'(e[31:0]));
        end
      end
      held     = rsp_valid && !rsp_ready;
      held_val = {rsp_id, rsp_data};
      check("fifo_no_overflow",
            {63'd0, (dut.fifo_occ == 2'd2) && dut.push_rsp && !(rsp_valid && rsp_ready)}, 64'd0);
    end
  end

  task automatic wait_accept(input int i, output int t);
    bit got = 0;
    t = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) begin
        got = 1;
        t = cyc;
      end
    end
    if (!got) fail("accept_timeout");
  endtask

  task automatic wait_rsp(output int t);
    bit got = 0;
    t = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        t = cyc;
      end
    end
    if (!got) fail("rsp_timeout");
  endtask

  task automatic wait_idle(input int limit);
    bit got = 0;
    for (int k = 0; k < limit && !got; k++) begin
      @(negedge clk);
      if (rq0.size() == 0 && rq1.size() == 0 && exp_q.size() == 0 && !busy && !rsp_valid)
        got = 1;
    end
    if (!got) fail("idle_timeout");
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, base;
    logic [31:0] op;
    reset = 1'b1;
    rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_mul_nibble", 64'(mul_nibble), 64'd0);
    check("rst_mul_reset", 64'(mul_reset), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Single job latency and value
    rq0.push_back({16'h1234, 16'h5678});
    wait_accept(0, t0);
    wait_rsp(t1);
    check("latency", 64'(t1 - t0), 64'd14);
    check("t_single_data", 64'(rsp_data), 64'h06260060);
    check("t_single_id", 64'(rsp_id), 64'd0);
    wait_idle(100);

    // Requester 1: max operands then zero operand
    rq1.push_back({16'hFFFF, 16'hFFFF});
    rq1.push_back({16'h0000, 16'hBEEF});
    wait_idle(100);

    // Both requesters continuously valid
    base = grant_id.size();
    for (int k = 0; k < 3; k++) begin
      rq0.push_back($urandom);
      rq1.push_back($urandom);
    end
    wait_idle(200);
    check("rr_count", 64'(grant_id.size() - base), 64'd6);
    if (grant_id.size() >= base + 6) begin
      check("rr_first", 64'(grant_id[base]), 64'd0);
      for (int k = 1; k < 6; k++) begin
        check("rr_alternate", 64'(grant_id[base + k] != grant_id[base + k - 1]), 64'd1);
        check("rr_spacing", 64'(grant_cyc[base + k] - grant_cyc[base + k - 1]), 64'd13);
      end
    end

    // Back-pressure: FIFO fills, third accept withheld
    @(posedge clk); #1 rsp_ready = 1'b0;
    base = grant_id.size();
    for (int k = 0; k < 3; k++) begin
      rq0.push_back($urandom);
      rq1.push_back($urandom);
    end
    repeat (45) @(negedge clk);
    check("bp_accepts", 64'(grant_id.size() - base), 64'd2);
    check("bp_busy", 64'(busy), 64'd0);
    check("bp_occ", 64'(dut.fifo_occ), 64'd2);
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_idle(300);
    check("bp_resumed", 64'(grant_id.size() - base), 64'd6);

    // Reset during LOAD3
    op = $urandom;
    rq0.push_back(op);
    wait_accept(0, t0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mid_load3_nibble", 64'(mul_nibble), 64'(op[19:16]));
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_mul_reset", 64'(mul_reset), 64'd1);
    check("mid_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    base = grant_id.size();
    rq0.push_back($urandom);
    rq1.push_back($urandom);
    wait_idle(100);
    check("mid_first_grant", 64'(grant_id.size() > base ? grant_id[base] : 9), 64'd0);

    // Simultaneous push and pop in OUT3 with one entry held
    @(posedge clk); #1 rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) rq0.push_back($urandom);
    wait_accept(0, t0);
    wait_accept(0, t1);
    check("pp_b2b_spacing", 64'(t1 - t0), 64'd13);
    repeat (13) @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("pp_occ_before", 64'(dut.fifo_occ), 64'd1);
    check("pp_accept_in_out3", 64'(req_valid[0] && req_ready[0]), 64'd1);
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("pp_occ_after", 64'(dut.fifo_occ), 64'd1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
